// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronises and glitch-filters A/B/index, then turns
// filtered Gray transitions into step, index-load and illegal-transition pulses.
//
// state | meaning
// PRIME | post-reset settle; filtered levels seeded straight from the synchronisers
// TRACK | filtered A/B compared cycle to cycle for steps, errors and index loads
module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 qa,
    input  logic                 qb,
    input  logic                 idx,
    output logic                 step_en,
    output logic                 step_up,
    output logic                 load_req,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [1:0]           state_ab
);
    localparam int CNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    typedef enum logic {
        PRIME = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_a, sync_b, sync_i;
    logic [2:0]               raw_s;
    logic [2:0]               filt_q, filt_d;
    logic [2:0]               prev_q, prev_d;
    logic [2:0][CNT_W-1:0]    fcnt_q, fcnt_d;
    logic [CNT_W-1:0]         prime_q, prime_d;
    logic                     step_en_d, step_up_d, load_req_d, err_pulse_d;
    logic [ERR_CNT_W-1:0]     err_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
            sync_i <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], qa};
            sync_b <= {sync_b[SYNC_STAGES-2:0], qb};
            sync_i <= {sync_i[SYNC_STAGES-2:0], idx};
        end
    end

    // Channel packing used throughout: bit 2 = A, bit 1 = B, bit 0 = index.
    assign raw_s    = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1], sync_i[SYNC_STAGES-1]};
    assign state_ab = filt_q[2:1];

    always_comb begin
        state_d     = state_q;
        filt_d      = filt_q;
        prev_d      = prev_q;
        fcnt_d      = fcnt_q;
        prime_d     = prime_q;
        step_en_d   = 1'b0;
        step_up_d   = step_up;
        load_req_d  = 1'b0;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt;

        case (state_q)
            PRIME: begin
                if (prime_q == CNT_LAST) begin
                    filt_d  = raw_s;
                    prev_d  = raw_s;
                    fcnt_d  = '0;
                    state_d = TRACK;
                end else begin
                    prime_d = prime_q + CNT_W'(1);
                end
            end
            TRACK: begin
                for (int ch = 0; ch < 3; ch++) begin
                    if (raw_s[ch] != filt_q[ch]) begin
                        if (fcnt_q[ch] == CNT_LAST) begin
                            filt_d[ch] = raw_s[ch];
                            fcnt_d[ch] = '0;
                        end else begin
                            fcnt_d[ch] = fcnt_q[ch] + CNT_W'(1);
                        end
                    end else begin
                        fcnt_d[ch] = '0;
                    end
                end
                prev_d = filt_q;

                case ({prev_q[2:1], filt_q[2:1]})
                    4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
                        step_en_d = 1'b1;
                        step_up_d = 1'b1;
                    end
                    4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
                        step_en_d = 1'b1;
                        step_up_d = 1'b0;
                    end
                    4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: begin
                        err_pulse_d = 1'b1;
                        if (err_cnt != '1)
                            err_cnt_d = err_cnt + ERR_CNT_W'(1);
                    end
                    default: ;
                endcase

                if (filt_q[0] && !prev_q[0] && (filt_q[2:1] == 2'b00))
                    load_req_d = 1'b1;
            end
            default: state_d = PRIME;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PRIME;
            filt_q    <= '0;
            prev_q    <= '0;
            fcnt_q    <= '0;
            prime_q   <= '0;
            step_en   <= 1'b0;
            step_up   <= 1'b0;
            load_req  <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            filt_q    <= filt_d;
            prev_q    <= prev_d;
            fcnt_q    <= fcnt_d;
            prime_q   <= prime_d;
            step_en   <= step_en_d;
            step_up   <= step_up_d;
            load_req  <= load_req_d;
            err_pulse <= err_pulse_d;
            err_cnt   <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed encoder scenarios plus random pin activity,
// every cycle compared against a history-lookback model of the pin-to-pulse rules.
module tb_quad_step_decoder;
    localparam int S  = 2;
    localparam int F  = 4;
    localparam int EW = 8;
    localparam int SAT = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          qa = 1'b0, qb = 1'b0, idx = 1'b0;
    logic          step_en, step_up, load_req, err_pulse;
    logic [EW-1:0] err_cnt;
    logic [1:0]    state_ab;

    quad_step_decoder #(.SYNC_STAGES(S), .FILT_CYCLES(F), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst(rst), .qa(qa), .qb(qb), .idx(idx),
        .step_en(step_en), .step_up(step_up), .load_req(load_req),
        .err_pulse(err_pulse), .err_cnt(err_cnt), .state_ab(state_ab)
    );

    always #5 clk = ~clk;

    // Model: pin_h[k-1] is {A,B,idx} sampled at the k-th edge after reset release;
    // filt_h[k-1] is the filtered level holding after that edge.
    bit [2:0] pin_h[$];
    bit [2:0] filt_h[$];
    int       edge_n = 0;
    bit [2:0] m_filt = '0;
    bit       m_step_en = 0, m_step_up = 0, m_load = 0, m_err = 0;
    int       m_err_cnt = 0;

    function automatic bit [2:0] vis(int e);
        int k = e - S;
        if (k < 1) return 3'b000;
        return pin_h[k-1];
    endfunction

    // Position along the up sequence 00 -> 10 -> 11 -> 01.
    function automatic int pos(bit [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit [2:0] v, f1, f2;
        bit       hold;
        int       d;
        if (rst) begin
            pin_h.delete();
            filt_h.delete();
            edge_n    = 0;
            m_filt    = '0;
            m_step_en = 0;
            m_step_up = 0;
            m_load    = 0;
            m_err     = 0;
            m_err_cnt = 0;
        end else begin
            edge_n++;
            pin_h.push_back({qa, qb, idx});
            if (edge_n == F) begin
                m_filt = vis(edge_n);
            end else if (edge_n >= 2 * F) begin
                for (int ch = 0; ch < 3; ch++) begin
                    hold = 1;
                    for (int j = 0; j < F; j++) begin
                        v = vis(edge_n - j);
                        if (v[ch] == m_filt[ch]) hold = 0;
                    end
                    if (hold) begin
                        v = vis(edge_n);
                        m_filt[ch] = v[ch];
                    end
                end
            end
            filt_h.push_back(m_filt);
            m_step_en = 0;
            m_load    = 0;
            m_err     = 0;
            if (edge_n >= F + 2) begin
                f1 = filt_h[edge_n-2];
                f2 = filt_h[edge_n-3];
                d  = (pos(f1[2:1]) - pos(f2[2:1]) + 4) % 4;
                if (d == 1) begin
                    m_step_en = 1;
                    m_step_up = 1;
                end else if (d == 3) begin
                    m_step_en = 1;
                    m_step_up = 0;
                end else if (d == 2) begin
                    m_err = 1;
                    if (m_err_cnt < SAT) m_err_cnt++;
                end
                m_load = f1[0] && !f2[0] && (f1[2:1] == 2'b00);
            end
        end
    end

    int n_vec = 0, n_err = 0;
    int n_step = 0, n_errp = 0, n_load = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("state_ab",  int'(state_ab),  int'(m_filt[2:1]));
        chk("step_en",   int'(step_en),   int'(m_step_en));
        chk("step_up",   int'(step_up),   int'(m_step_up));
        chk("load_req",  int'(load_req),  int'(m_load));
        chk("err_pulse", int'(err_pulse), int'(m_err));
        chk("err_cnt",   int'(err_cnt),   m_err_cnt);
        if (step_en)   n_step++;
        if (err_pulse) n_errp++;
        if (load_req)  n_load++;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int base_s, base_e, base_l, r;
        bit [1:0] up_seq[4];
        bit [1:0] dn_seq[4];
        up_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        dn_seq = '{2'b01, 2'b11, 2'b10, 2'b00};

        // 1: pins at 11 through reset and release
        qa = 1; qb = 1; idx = 0; rst = 1;
        cycles(3);
        base_s = n_step; base_e = n_errp;
        rst = 0;
        cycles(10);
        chk("t1_state_ab", int'(state_ab), 3);
        chk("t1_steps", n_step - base_s, 0);
        chk("t1_errs", n_errp - base_e, 0);
        chk("t1_err_cnt", int'(err_cnt), 0);

        // 2: up sequence from 00, latency 7 cycles from pin change
        rst = 1; qa = 0; qb = 0;
        cycles(3);
        rst = 0;
        cycles(10);
        base_s = n_step;
        for (int i = 0; i < 4; i++) begin
            {qa, qb} = up_seq[i];
            cycles(6);
            chk("t2_state_ab_c6", int'(state_ab), int'(up_seq[i]));
            chk("t2_step_c6", int'(step_en), 0);
            tick();
            chk("t2_step_c7", int'(step_en), 1);
            chk("t2_dir_c7", int'(step_up), 1);
            cycles(3);
        end
        chk("t2_steps", n_step - base_s, 4);

        // 3: down sequence
        base_s = n_step;
        for (int i = 0; i < 4; i++) begin
            {qa, qb} = dn_seq[i];
            cycles(7);
            chk("t3_step_c7", int'(step_en), 1);
            chk("t3_dir_c7", int'(step_up), 0);
            cycles(3);
        end
        cycles(10);
        chk("t3_steps", n_step - base_s, 4);
        chk("t3_dir_hold", int'(step_up), 0);

        // 4: 3-cycle glitch rejected, 4-cycle hold accepted
        base_s = n_step;
        qa = 1;
        cycles(3);
        qa = 0;
        cycles(12);
        chk("t4_glitch_steps", n_step - base_s, 0);
        chk("t4_glitch_state", int'(state_ab), 0);
        qa = 1;
        cycles(4);
        qa = 0;
        cycles(5);
        chk("t4_hold_steps", n_step - base_s, 1);
        cycles(10);

        // 5: simultaneous A/B toggles are illegal, counter saturates
        base_s = n_step; base_e = n_errp;
        for (int i = 0; i < 300; i++) begin
            qa = ~qa; qb = ~qb;
            cycles(6);
        end
        cycles(10);
        chk("t5_err_pulses", n_errp - base_e, 300);
        chk("t5_steps", n_step - base_s, 0);
        chk("t5_err_cnt", int'(err_cnt), SAT);
        chk("t5_state_ab", int'(state_ab), 0);

        // 6: index load only at AB=00, then asynchronous reset mid-motion
        base_l = n_load;
        idx = 1;
        cycles(8);
        idx = 0;
        cycles(12);
        chk("t6_load_at_00", n_load - base_l, 1);
        qa = 1;
        cycles(10);
        base_l = n_load;
        idx = 1;
        cycles(8);
        idx = 0;
        cycles(12);
        chk("t6_load_at_10", n_load - base_l, 0);
        qb = 1;
        cycles(5);
        #1 rst = 1;
        #1;
        chk("t6_rst_state_ab", int'(state_ab), 0);
        chk("t6_rst_step_en", int'(step_en), 0);
        chk("t6_rst_step_up", int'(step_up), 0);
        chk("t6_rst_load", int'(load_req), 0);
        chk("t6_rst_err", int'(err_pulse), 0);
        chk("t6_rst_err_cnt", int'(err_cnt), 0);
        cycles(3);
        base_s = n_step; base_e = n_errp;
        rst = 0;
        cycles(10);
        chk("t6_prime_state_ab", int'(state_ab), 3);
        chk("t6_prime_steps", n_step - base_s, 0);
        chk("t6_prime_errs", n_errp - base_e, 0);

        // Random pin activity, including glitches and occasional resets
        for (int it = 0; it < 500; it++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 2)      qa = ~qa;
            else if (r <= 5) qb = ~qb;
            else if (r == 6) begin qa = ~qa; qb = ~qb; end
            else             idx = ~idx;
            if ($urandom_range(0, 199) == 0) begin
                rst = 1;
                cycles(2);
                rst = 0;
            end
            cycles(int'($urandom_range(1, 10)));
        end
        cycles(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
